// File: rtl/rv_pkg.sv
// Shared constants and the writeback source encoding for the integer register file.
package rv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter between the ALU and load writeback paths.
module rr_arbiter2
    import rv_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_ready,
    output logic mem_ready,
    output logic grant,
    output src_e winner
);

    src_e ptr_q;
    src_e ptr_d;

    // Ready/grant decode; the pointer only matters when both paths are requesting.
    always_comb begin
        alu_ready = !reset && (!mem_valid || (ptr_q == SRC_ALU));
        mem_ready = !reset && (!alu_valid || (ptr_q == SRC_MEM));
        grant     = (alu_valid && alu_ready) || (mem_valid && mem_ready);
        winner    = (mem_valid && mem_ready) ? SRC_MEM : SRC_ALU;
        ptr_d     = ptr_q;
        // Contention always yields a grant, so flipping here hands the next tie to the loser.
        if (!reset && alu_valid && mem_valid) begin
            ptr_d = (ptr_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end
    end

    // Pointer register; favours the ALU out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= SRC_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_writeback_scheduler.sv
// Register-file write-port scheduler with a per-register busy scoreboard for RAW stalls.
module rf_writeback_scheduler
    import rv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            rf_write,
    output logic [AW-1:0]   rf_c_address,
    output logic [XLEN-1:0] rf_c_in,
    input  logic [AW-1:0]   a_address,
    input  logic [AW-1:0]   b_address,
    output logic            a_busy,
    output logic            b_busy
);

    logic             grant;
    src_e             winner;
    logic [AW-1:0]    sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    rr_arbiter2 u_arb (
        .clock     (clock),
        .reset     (reset),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .alu_ready (alu_ready),
        .mem_ready (mem_ready),
        .grant     (grant),
        .winner    (winner)
    );

    // Payload of the granted source.
    always_comb begin
        sel_rd   = (winner == SRC_MEM) ? mem_rd : alu_rd;
        sel_data = (winner == SRC_MEM) ? mem_data : alu_data;
    end

    // Write-port output register; address and data hold when nothing is granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_write     <= 1'b0;
            rf_c_address <= '0;
            rf_c_in      <= '0;
        end else begin
            rf_write <= grant && (sel_rd != '0);
            if (grant) begin
                rf_c_address <= sel_rd;
                rf_c_in      <= sel_data;
            end
        end
    end

    // Scoreboard next state: clear on the write edge, then set so a same-cycle issue wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_write) begin
            busy_d[rf_c_address] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Source-operand hazard lookup; bit 0 is never set.
    always_comb begin
        a_busy = busy_q[a_address];
        b_busy = busy_q[b_address];
    end

endmodule

// File: doc/rf_writeback_scheduler.md
# rf_writeback_scheduler

Write-port scheduler and scoreboard for the 32 x 32-bit integer register file. It arbitrates the single write port between the ALU writeback path and the load/memory response path, and drives the file's write, destination-address and write-data inputs from registered outputs. It also keeps a per-register busy scoreboard so decode can stall on RAW hazards. It sits between the execute/memory stages and the register file.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural register count (index 0 hardwired zero)
- AW, 5, register address width, equal to clog2(NREGS)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  decode issues an instruction that writes issue_rd
- issue_rd  in  AW  destination of the issued instruction
- alu_valid / alu_ready  in / out  1  ALU writeback handshake
- alu_rd, alu_data  in  AW, XLEN  ALU destination and result
- mem_valid / mem_ready  in / out  1  load-response writeback handshake
- mem_rd, mem_data  in  AW, XLEN  load destination and data
- rf_write  out  1  write strobe to the register file
- rf_c_address  out  AW  destination address to the register file
- rf_c_in  out  XLEN  write data to the register file
- a_address, b_address  in  AW  decode source-operand addresses (same as the register-file read ports)
- a_busy, b_busy  out  1  source has a pending write

## Operation
- Arbitration:
  - A source is granted when `<src>_valid && <src>_ready`. At most one grant per cycle.
  - The ready outputs are combinational. With one source valid, that source is ready.
  - With both valid, a round-robin pointer picks the winner. After reset the pointer favours ALU.
  - The pointer flips to the other source only on a grant when both were valid.
  - The loser's ready is low and it holds its request.
- Output register:
  - On a grant, the next rf_write = (rd != 0), rf_c_address = rd, rf_c_in = data.
  - With no grant, rf_write = 0. Address and data hold their last value.
- rd = 0 requests are accepted, complete the handshake and produce no write.
- Scoreboard: busy[NREGS] with busy[0] constant 0.
  - issue_valid with issue_rd != 0 sets busy[issue_rd].
  - rf_write clears busy[rf_c_address] on the same edge the file is written.
  - Set and clear of the same register in one cycle: set wins.
- a_busy = busy[a_address]; b_busy = busy[b_address]. Both are combinational and are 0 for address 0.
- Issue is illegal when busy[issue_rd] is already set (WAW); decode must stall. The bench asserts this; the RTL behaviour in that case is unspecified.

## Timing
- Reset values: rf_write 0, rf_c_address 0, rf_c_in 0, all busy bits 0, round-robin pointer = ALU.
- While reset is high, ready outputs are 0.
- Reset asserted mid-operation drops any granted but unwritten result and clears the scoreboard.
- Latency:
  - Grant at edge N: rf_write is high during cycle N+1, and the file updates at edge N+1.
  - busy drops from cycle N+2. Reads return the new data from cycle N+2.
- Throughput is one write per cycle. A source held off by the other waits at most one cycle when both stream continuously.
- busy reflects an issue from the cycle after issue_valid.

## Structure
- Shared package rv_pkg holds XLEN, NREGS, AW and the arbiter-source enum (SRC_ALU, SRC_MEM).
- One natural sub-module: rr_arbiter2, the two-requester round-robin arbiter with its pointer register.
- The scoreboard and the output register stay in the top module.

## Test plan
- After reset, issue rd=5; ALU writes rd=5 data 0x1234_5678 at edge N -> rf_write=1, address 5, data 0x12345678 in cycle N+1; a_busy (a_address=5) is 1 through N+1 and 0 from N+2.
- ALU and mem both valid for 4 cycles (rd 1..4 and 11..14) -> grants go ALU, MEM, ALU, MEM in that order with no idle write cycle; each loser holds its payload stable.
- mem_valid with rd=0, data 0xFFFF_FFFF -> mem_ready=1, no rf_write pulse, no busy change.
- In one cycle, issue rd=7 while rf_write clears rd=7 -> busy[7] stays 1 afterwards.
- Reset pulsed in the cycle after a grant with busy[3,9] set -> rf_write 0 the next cycle, all busy outputs 0, next arbitration favours ALU.
- Random issue/writeback streams with the WAW rule respected -> each issued rd is cleared exactly once; final busy vector all zero after drain.
